grf_file: RTL and testbench
===========================

// Module: grf_file
// PURPOSE
// - General register file (32 x 32-bit): the responder end of the ID-stage read interface (RA1/RA2 -> RD1/RD2).
// - Two combinational read ports with write-to-read bypass (inner forward), so the ID stage only forwards from EX/MEM.
// - One synchronous write port driven by the WB stage; $0 is hardwired to zero.
// - Registered write-trace outputs and a write counter for the bench and debug.
// PARAMETERS
// - NREG   32  number of architectural registers (power of two)
// - AW     5   address width, log2(NREG)
// - DW     32  data width
// PORTS
// - clk      in   1   single clock, all state updates on posedge
// - reset    in   1   asynchronous, active-high; clears all state
// - RA1      in   AW  read address port 1 (rs)
// - RA2      in   AW  read address port 2 (rt)
// - RD1      out  DW  read data port 1, combinational
// - RD2      out  DW  read data port 2, combinational
// - WE       in   1   write enable from WB
// - WA       in   AW  write address
// - WD       in   DW  write data
// - WPC      in   32  PC of the writing instruction (trace only)
// - trace_we    out 1   1 for one cycle after each effective write
// - trace_pc    out 32  WPC of that write
// - trace_addr  out AW  WA of that write
// - trace_data  out DW  WD of that write
// - wcount      out 32  number of effective writes since reset
// BEHAVIOUR
// - Effective write: WE==1 && WA!=0. Sampled on posedge clk; reg[WA] <= WD.
// - WE==1 && WA==0: no state change, no trace pulse, wcount unchanged.
// - Read port n (n=1,2), combinational, priority order:
//   RAn==0 -> 0; else effective write && WA==RAn -> WD (bypass); else reg[RAn].
// - Both ports may read the same address, and may both hit the bypass in one cycle.
// - Trace: on each posedge, trace_we <= effective write; if effective, trace_pc/addr/data <= WPC/WA/WD,
//   else those three hold their previous value. Latency 1 cycle from write edge.
// - wcount increments by 1 per effective write; wraps 32'hFFFF_FFFF -> 0 without flag.
// - reset asserted (any time, no clock needed): reg[1..NREG-1], trace_we, trace_pc, trace_addr,
//   trace_data, wcount all -> 0 immediately; RD1/RD2 then read 0 except via bypass.
// - While reset is high, no write commits on any edge; the first commit is on the first posedge with reset low.
// - reg[0] is never stored (no flop); reads of address 0 return 0 regardless of WE/WA/WD.
// - No X propagation: every read path has a defined value after reset.
// STRUCTURE
// - Shared package/header: GRF_NREG, GRF_AW, GRF_DW constants; register $0 / $ra (31) index constants.
// - Sub-module grf_read_port: one combinational read port (addr, bank slice select, bypass compare);
//   instantiated twice. Storage, write logic, trace and counter stay in grf_file.
// TESTING
// - Reset check: assert reset mid-run after writing $5=0x1234 -> RD1 with RA1=5 reads 0 immediately,
//   wcount==0, trace_we==0, without a clock edge.
// - Write/read: WE=1,WA=8,WD=0xDEADBEEF,WPC=0x3000 -> next cycle RA1=8 gives 0xDEADBEEF;
//   trace_we=1, trace_pc=0x3000, trace_addr=8, wcount=1.
// - Bypass: same cycle WE=1,WA=9,WD=0x55, RA1=RA2=9 -> RD1=RD2=0x55 before the edge; old value of $9 not visible.
// - $0: WE=1,WA=0,WD=0xFFFF_FFFF -> RA1=0 reads 0 same cycle and after; trace_we stays 0, wcount unchanged.
// - Back-to-back: writes $1..$31 with WD=idx*0x1111 on consecutive cycles -> all 31 read back correctly,
//   wcount=31, trace_we high for 31 consecutive cycles.
// - Wrap: force 0xFFFF_FFFF effective writes (or preload wcount via bench hook) -> next effective write gives wcount=0.

Source files
------------

// File: rtl/grf_file_pkg.sv
// grf_file_pkg: shared sizing and well-known register indices
// for the general register file.
package grf_file_pkg;

    localparam int GRF_NREG = 32;
    localparam int GRF_AW   = 5;
    localparam int GRF_DW   = 32;

    localparam logic [GRF_AW-1:0] GRF_R0 = 5'd0;
    localparam logic [GRF_AW-1:0] GRF_RA = 5'd31;

endpackage

// File: rtl/grf_read_port.sv
// grf_read_port: one combinational read port with inner forward
// from the same-cycle write.
module grf_read_port
    import grf_file_pkg::*;
#(
    parameter int NREG = GRF_NREG,
    parameter int AW   = GRF_AW,
    parameter int DW   = GRF_DW
) (
    input  logic [AW-1:0]            addr,
    input  logic [NREG-1:1][DW-1:0]  bank,
    input  logic                     wr_eff,
    input  logic [AW-1:0]            wa,
    input  logic [DW-1:0]            wd,
    output logic [DW-1:0]            rd
);

    always_comb begin
        rd = '0;
        unique case (1'b1)
            (addr == '0):             rd = '0;
            (wr_eff && (wa == addr)): rd = wd;
            default:                  rd = bank[addr];
        endcase
    end

endmodule

// File: rtl/grf_file.sv
// grf_file: 32x32 register file, two bypassed read ports, one
// write port, registered write trace and effective-write counter.
module grf_file
    import grf_file_pkg::*;
#(
    parameter int NREG = GRF_NREG,
    parameter int AW   = GRF_AW,
    parameter int DW   = GRF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] WD,
    input  logic [31:0]   WPC,
    output logic          trace_we,
    output logic [31:0]   trace_pc,
    output logic [AW-1:0] trace_addr,
    output logic [DW-1:0] trace_data,
    output logic [31:0]   wcount
);

    // $0 has no storage; the bank starts at index 1
    logic [NREG-1:1][DW-1:0] bank;
    logic                    wr_eff;

    assign wr_eff = WE && (WA != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank <= '0;
        end else if (wr_eff) begin
            bank[WA] <= WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trace_we   <= 1'b0;
            trace_pc   <= '0;
            trace_addr <= '0;
            trace_data <= '0;
            wcount     <= '0;
        end else begin
            trace_we <= wr_eff;
            if (wr_eff) begin
                trace_pc   <= WPC;
                trace_addr <= WA;
                trace_data <= WD;
                wcount     <= wcount + 32'd1;
            end
        end
    end

    grf_read_port #(
        .NREG(NREG),
        .AW  (AW),
        .DW  (DW)
    ) u_rp1 (
        .addr  (RA1),
        .bank  (bank),
        .wr_eff(wr_eff),
        .wa    (WA),
        .wd    (WD),
        .rd    (RD1)
    );

    grf_read_port #(
        .NREG(NREG),
        .AW  (AW),
        .DW  (DW)
    ) u_rp2 (
        .addr  (RA2),
        .bank  (bank),
        .wr_eff(wr_eff),
        .wa    (WA),
        .wd    (WD),
        .rd    (RD2)
    );

endmodule

// File: tb/tb_grf_file.sv
// tb_grf_file: randomized and directed checks of grf_file against
// an array-based register file model.
module tb_grf_file;

    logic        clk;
    logic        reset;
    logic [4:0]  RA1, RA2, WA;
    logic [31:0] RD1, RD2, WD, WPC;
    logic        WE;
    logic        trace_we;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [31:0] wcount;

    grf_file dut (
        .clk       (clk),
        .reset     (reset),
        .RA1       (RA1),
        .RA2       (RA2),
        .RD1       (RD1),
        .RD2       (RD2),
        .WE        (WE),
        .WA        (WA),
        .WD        (WD),
        .WPC       (WPC),
        .trace_we  (trace_we),
        .trace_pc  (trace_pc),
        .trace_addr(trace_addr),
        .trace_data(trace_data),
        .wcount    (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0] m_reg [32];
    logic        m_twe;
    logic [31:0] m_tpc;
    logic [4:0]  m_taddr;
    logic [31:0] m_tdata;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_twe = 1'b0;
        m_tpc = '0;
        m_taddr = '0;
        m_tdata = '0;
        m_cnt = '0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (WE && WA != 5'd0 && WA == ra) return WD;
        return m_reg[ra];
    endfunction

    // entered just after a posedge; leaves just after the next one
    task automatic cyc(input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] wpc,
                       input logic [4:0] ra1, input logic [4:0] ra2);
        WE = we; WA = wa; WD = wd; WPC = wpc;
        RA1 = ra1; RA2 = ra2;
        #4;
        chk("rd1", RD1, exp_rd(ra1));
        chk("rd2", RD2, exp_rd(ra2));
        @(posedge clk);
        m_twe = we && wa != 5'd0;
        if (m_twe) begin
            m_reg[wa] = wd;
            m_tpc = wpc;
            m_taddr = wa;
            m_tdata = wd;
            m_cnt = m_cnt + 32'd1;
        end
        #1;
        chk("trace_we", {31'b0, trace_we}, {31'b0, m_twe});
        chk("trace_pc", trace_pc, m_tpc);
        chk("trace_addr", {27'b0, trace_addr}, {27'b0, m_taddr});
        chk("trace_data", trace_data, m_tdata);
        chk("wcount", wcount, m_cnt);
    endtask

    initial begin
        reset = 1'b1;
        WE = 0; WA = 0; WD = 0; WPC = 0;
        RA1 = 5'd5; RA2 = 5'd0;
        m_clear();
        #1;
        chk("rst_rd1", RD1, 32'h0);
        chk("rst_wcount", wcount, 32'h0);
        chk("rst_trace_we", {31'b0, trace_we}, 32'h0);
        // write attempted during reset must not commit
        WE = 1; WA = 5'd3; WD = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        WE = 0;
        chk("rst_nocommit", wcount, 32'h0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 5'd3, 5'd3);

        // write then read back
        cyc(1, 5'd8, 32'hDEAD_BEEF, 32'h3000, 5'd8, 5'd0);
        cyc(0, 0, 0, 0, 5'd8, 5'd8);
        // bypass on both ports hides the old $9
        cyc(1, 5'd9, 32'h11, 32'h3004, 5'd1, 5'd2);
        cyc(1, 5'd9, 32'h55, 32'h3008, 5'd9, 5'd9);
        cyc(0, 0, 0, 0, 5'd9, 5'd9);
        // $0 write is ignored everywhere
        cyc(1, 5'd0, 32'hFFFF_FFFF, 32'h300C, 5'd0, 5'd0);
        cyc(0, 0, 0, 0, 5'd0, 5'd8);

        // back-to-back writes $1..$31
        for (int i = 1; i < 32; i++)
            cyc(1, 5'(i), 32'(i) * 32'h1111, 32'h4000 + 32'(4 * i),
                5'(i), 5'(i - 1));
        chk("b2b_wcount", wcount, 32'd34);
        for (int i = 1; i < 32; i++)
            cyc(0, 0, 0, 0, 5'(i), 5'(32 - i));

        // random traffic
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(0, 3) != 0, 5'($urandom), $urandom,
                $urandom, 5'($urandom), 5'($urandom));

        // asynchronous reset mid-cycle, no clock edge needed
        cyc(1, 5'd5, 32'h1234, 32'h5000, 5'd5, 5'd0);
        WE = 0; RA1 = 5'd5; RA2 = 5'd8;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rd1", RD1, 32'h0);
        chk("async_rd2", RD2, 32'h0);
        chk("async_wcount", wcount, 32'h0);
        chk("async_trace_we", {31'b0, trace_we}, 32'h0);
        chk("async_trace_pc", trace_pc, 32'h0);
        m_clear();
        // bypass still works while held in reset
        WE = 1; WA = 5'd7; WD = 32'hCAFE; RA1 = 5'd7;
        #1;
        chk("rst_bypass", RD1, 32'hCAFE);
        @(posedge clk);
        #1;
        chk("rst_hold_wcount", wcount, 32'h0);
        WE = 0;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 5'd7, 5'd5);

        // counter wrap from preloaded all-ones
        dut.wcount = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        cyc(1, 5'd0, 32'h1, 32'h6000, 5'd0, 5'd0);
        chk("wrap_hold", wcount, 32'hFFFF_FFFF);
        cyc(1, 5'd31, 32'h77, 32'h6004, 5'd31, 5'd31);
        chk("wrap_zero", wcount, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
